// File: rtl/gate_tb_pkg.sv
// gate_tb_pkg
//   Shared definitions for the truth-table sequencer: the FSM state encoding
//   and ready-made expected truth tables for common 2-input gates.
//   Bit i of a truth table is the expected gate output for input vector i,
//   where vector i drives {A,B} = i (B is the LSB).
package gate_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_XOR2 = 4'b0110;

endpackage

// File: rtl/settle_timer.sv
// settle_timer
//   Down-counter that times the settle window after a vector is applied.
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     load     load the counter with load_val (takes priority over tick)
//     load_val number of settle cycles to count
//     tick     decrement the counter by one
//     expire   high while the counter holds 1, i.e. in the last settle cycle
module settle_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expire
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//   Walks every input vector of an N_IN-input gate, waits SETTLE cycles for
//   the gate output to settle, samples Y and compares it against EXP_TT.
//   Reports the mismatch count, the first failing vector and a pass flag.
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     start    begin a run (only honoured in IDLE)
//     vec      inputs driven to the gate under test
//     Y        gate-under-test output
//     busy     high in every state except IDLE
//     done     one-cycle pulse in the DONE state
//     pass     result of the last completed run (1 = no mismatches)
//     err_cnt  mismatch count of the current or last run
//     fail_vec index of the first mismatching vector
//     fail_val fail_vec holds a valid index
module truth_table_sequencer
    import gate_tb_pkg::*;
#(
    parameter int                     N_IN   = 2,
    parameter int                     SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]   EXP_TT = TT_OR2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            Y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_val
);

    localparam int              ERR_W    = N_IN + 1;
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    state_t state;
    logic   settle_expire;

    settle_timer #(
        .W (4)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_APPLY),
        .load_val (4'(SETTLE)),
        .tick     (state == ST_SETTLE),
        .expire   (settle_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            vec      <= '0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
            fail_val <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Results of the previous run stay visible until the
                    // next start clears them.
                    if (start) begin
                        state    <= ST_APPLY;
                        vec      <= '0;
                        err_cnt  <= '0;
                        fail_vec <= '0;
                        fail_val <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    state <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_expire) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (Y != EXP_TT[vec]) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                        if (!fail_val) begin
                            fail_vec <= vec;
                            fail_val <= 1'b1;
                        end
                    end
                    if (vec == VEC_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        vec   <= vec + N_IN'(1);
                        state <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    // err_cnt already includes the final vector's result,
                    // which was registered on the edge leaving SAMPLE.
                    pass  <= (err_cnt == '0);
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; no other clock or reset input is permitted.
REQ-002 Parameter N_IN, default 2, SHALL give the number of inputs of the gate under test (1..6).
REQ-003 Parameter SETTLE, default 1, SHALL give the number of wait cycles between applying a vector and sampling Y (0..15).
REQ-004 Parameter EXP_TT, width 2**N_IN, default 4'b1110 (2-input OR), SHALL hold the expected output: bit i is the expected Y for vector i.
REQ-005 Ports SHALL be (name, direction, width, meaning):
  clk       in   1            rising-edge clock
  rst_n     in   1            asynchronous active-low reset
  start     in   1            begin a run; sampled only in IDLE
  vec       out  N_IN         inputs driven to the gate under test; vec[0]=B, vec[1]=A for N_IN=2
  Y         in   1            gate-under-test output
  busy      out  1            high in every state except IDLE
  done      out  1            one-cycle pulse at end of run
  pass      out  1            result of the last completed run; 1 = no mismatches
  err_cnt   out  N_IN+1       mismatch count of the current or last run
  fail_vec  out  N_IN         index of the first mismatching vector
  fail_val  out  1            fail_vec holds a valid index

Function
REQ-006 The FSM SHALL have exactly five states: IDLE, APPLY, SETTLE, SAMPLE and DONE.
REQ-007 IDLE SHALL go to APPLY when start=1, and SHALL clear vec, err_cnt, fail_vec and fail_val on that edge.
REQ-008 APPLY SHALL hold vec for one cycle, load the settle counter with SETTLE, and go to SETTLE (SETTLE>0) or to SAMPLE (SETTLE=0).
REQ-009 SETTLE SHALL decrement the counter each cycle and go to SAMPLE in the cycle the counter reaches 1.
REQ-010 SAMPLE SHALL compare Y with EXP_TT[vec]; on mismatch it SHALL increment err_cnt and, if fail_val=0, load fail_vec=vec and set fail_val=1.
REQ-011 SAMPLE SHALL go to APPLY with vec+1 when vec < 2**N_IN-1, otherwise it SHALL go to DONE with vec unchanged.
REQ-012 DONE SHALL last one cycle, assert done, latch pass=(err_cnt==0) including any final-vector mismatch, and return to IDLE.
REQ-013 vec SHALL remain stable through APPLY, SETTLE and SAMPLE of each vector.
REQ-014 Latency: with start high at edge k, done SHALL be high in the cycle beginning at edge k + 2**N_IN*(SETTLE+2) (12 cycles at the defaults).
REQ-015 start SHALL be ignored outside IDLE, and a start coincident with done SHALL NOT start a run.
REQ-016 err_cnt SHALL NOT saturate or wrap; its width covers the maximum of 2**N_IN mismatches.
REQ-017 pass, err_cnt, fail_vec and fail_val SHALL hold their last values in IDLE until the next start.

Reset
REQ-018 While rst_n=0 the block SHALL be in IDLE with vec=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0 and fail_val=0, regardless of clk.
REQ-019 Reset asserted mid-run SHALL abort the run immediately, with no done pulse and no pass update.
REQ-020 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Structure
REQ-021 Shared package gate_tb_pkg SHALL hold the FSM state enum and the default EXP_TT constants for OR2, AND2 and XOR2.
REQ-022 The settle counter SHALL be the sub-module settle_timer (load, tick and expire outputs); all other logic SHALL be in truth_table_sequencer.

Verification
REQ-023 Defaults with Y = vec[1]|vec[0]; pulse start: done at +12 cycles, pass=1, err_cnt=0, fail_val=0; vec walks 0,1,2,3.
REQ-024 Defaults with Y stuck at 1: err_cnt=1, fail_vec=0, fail_val=1, pass=0.
REQ-025 Defaults with Y = AND of the inputs: err_cnt=2, fail_vec=1, pass=0.
REQ-026 SETTLE=0 with the OR model: done at +8 cycles and pass=1; SETTLE=3: done at +20 cycles.
REQ-027 Pulse start again at cycle 5 of a run: no effect and done still at +12; start held high continuously: new run starts on the edge after DONE.
REQ-028 Drop rst_n at cycle 6 of a run: all outputs 0 immediately, no done pulse; a fresh run then completes normally.
